seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with BLANK/DRIVE phases per digit
// and a shadow/active value pair that swaps only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   num_i,
  input  logic                  load_i,
  output logic                  load_ack_o,
  input  logic                  en_i,
  input  logic [DIGITS-1:0]     digit_mask_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic [7:0]            blank_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            cath_o,
  output logic                  frame_o
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = (DIV_W > 8) ? DIV_W : 8;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_ok_q;
  logic [4*DIGITS-1:0] active_q, shadow_q;
  logic                pending_q;
  logic                phase_end;
  logic                xfer;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          cath_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign phase_end  = (cnt_q == '0);
  assign frame_o    = en_i && (state_q == S_DRIVE) && phase_end && (idx_q == LAST);
  assign xfer       = pending_q && (frame_o || (state_q == S_IDLE));
  assign load_ack_o = xfer;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run_ok_q) begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = CNT_W'(blank_i);
        end
      end
      S_BLANK: begin
        if (phase_end) begin
          state_d = S_DRIVE;
          cnt_d   = CNT_W'(div_i);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRIVE: begin
        if (phase_end) begin
          state_d = S_BLANK;
          cnt_d   = CNT_W'(blank_i);
          idx_d   = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!en_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are registered from the next state so they switch on the same
  // edge as the phase itself, never one cycle late.
  always_comb begin
    an_d   = '1;
    cath_d = '1;
    if (state_d == S_DRIVE) begin
      if (digit_mask_i[idx_d]) an_d[idx_d] = 1'b0;
      cath_d = seg_decode(active_q[{idx_d, 2'b00} +: 4]);
    end
  end

  // run_ok_q holds IDLE for one edge after reset release, so the first BLANK
  // starts on the second rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      run_ok_q  <= 1'b0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      an_o      <= '1;
      cath_o    <= '1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      run_ok_q <= 1'b1;
      an_o     <= an_d;
      cath_o   <= cath_d;
      if (xfer) active_q <= shadow_q;
      if (load_i) begin
        shadow_q  <= num_i;
        pending_q <= 1'b1;
      end else if (xfer) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: expected digit slots are queued per
// frame and compared as each DRIVE slot ends.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] num;
  logic        load;
  logic        load_ack;
  logic        en;
  logic [7:0]  mask;
  logic [15:0] div;
  logic [7:0]  blank;
  logic [7:0]  an;
  logic [6:0]  cath;
  logic        frame;

  seg7_scan_ctrl #(.DIGITS(8), .DIV_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .num_i(num), .load_i(load), .load_ack_o(load_ack),
    .en_i(en), .digit_mask_i(mask), .div_i(div), .blank_i(blank),
    .an_o(an), .cath_o(cath), .frame_o(frame)
  );

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  cath;
    int unsigned len;
  } slot_t;

  slot_t       sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned ncyc = 0;
  int unsigned ack_seen = 0;
  int unsigned last_frame_cyc = 0;
  bit          mon_on = 0;
  logic [31:0] exp_active = '0;
  logic [31:0] exp_shadow = '0;
  bit          exp_pending = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (load_ack) ack_seen++;
  endtask

  task automatic push_frame();
    slot_t s;
    for (int k = 0; k < 8; k++) begin
      s.an   = mask[k] ? ~(8'h01 << k) : 8'hFF;
      s.cath = seg_ref(exp_active[4*k +: 4]);
      s.len  = 32'(div) + 1;
      sb_q.push_back(s);
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    num  = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    exp_shadow  = v;
    exp_pending = 1;
  endtask

  task automatic frame_step(input bit check_period);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!frame && n < 200);
    if (!frame) check("frame_timeout", 32'd0, 32'd1);
    if (check_period) check("frame_period", ncyc - last_frame_cyc, 32'd48);
    last_frame_cyc = ncyc;
    check("ack_at_frame", {31'd0, load_ack}, {31'd0, exp_pending});
    if (exp_pending) begin
      exp_active  = exp_shadow;
      exp_pending = 0;
    end
  endtask

  task automatic ticks_to_drive(input string tag, input int unsigned exp_n);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (cath == 7'h7F && n < 20);
    check(tag, n, exp_n);
  endtask

  // Slot monitor: a slot is a run of non-blank cathodes; all decodes differ from 7F.
  initial begin : monitor
    bit          in_slot = 0;
    int unsigned s_len = 0;
    logic [7:0]  s_an = '0;
    logic [6:0]  s_cath = '0;
    slot_t       e;
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        in_slot = 0;
      end else if (cath != 7'h7F) begin
        if (!in_slot) begin
          in_slot = 1;
          s_len   = 0;
          s_an    = an;
          s_cath  = cath;
        end
        s_len++;
      end else if (in_slot) begin
        in_slot = 0;
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("slot_an", {24'd0, s_an}, {24'd0, e.an});
          check("slot_cath", {25'd0, s_cath}, {25'd0, e.cath});
          check("slot_len", s_len, e.len);
        end
      end else begin
        check("blank_an", {24'd0, an}, 32'hFF);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned ack0;
    rst = 1'b1; en = 1'b0; load = 1'b0; num = '0;
    mask = 8'hFF; div = 16'd3; blank = 8'd1;
    repeat (3) tick();
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_cath", {25'd0, cath}, 32'h7F);
    check("rst_frame", {31'd0, frame}, 32'd0);
    check("rst_ack", {31'd0, load_ack}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_cath", {25'd0, cath}, 32'h7F);

    // Load from IDLE: ack the cycle after capture, then start scanning.
    do_load(32'h76543210);
    check("ack_idle", {31'd0, load_ack}, 32'd1);
    exp_active = exp_shadow; exp_pending = 0;
    push_frame();
    mon_on = 1;
    en = 1'b1;
    ticks_to_drive("first_drive", 3);
    check("d0_an", {24'd0, an}, 32'hFE);
    check("d0_cath", {25'd0, cath}, 32'b0000001);
    repeat (4) tick();
    check("gap1_cath", {25'd0, cath}, 32'h7F);
    tick();
    check("gap2_cath", {25'd0, cath}, 32'h7F);
    tick();
    check("d1_an", {24'd0, an}, 32'hFD);
    check("d1_cath", {25'd0, cath}, {25'd0, seg_ref(4'h1)});

    frame_step(0); push_frame();
    frame_step(1); push_frame();

    // Mid-frame load: current frame unchanged, swap at frame_o.
    repeat (20) tick();
    do_load(32'h89ABCDEF);
    frame_step(1); push_frame();
    repeat (3) tick();
    check("new_d0_cath", {25'd0, cath}, 32'b0111000);

    // Two loads in one frame: last wins, single ack.
    ack0 = ack_seen;
    repeat (10) tick();
    do_load(32'h11111111);
    repeat (10) tick();
    do_load(32'h22222222);
    frame_step(1); push_frame();
    frame_step(1);
    check("single_ack", ack_seen - ack0, 32'd1);

    // Masked upper digits for one frame.
    mask = 8'h0F; push_frame();
    frame_step(1);
    mask = 8'hFF; push_frame();

    // Abort mid-DRIVE of digit 3, then restart.
    repeat (22) tick();
    check("d3_an", {24'd0, an}, 32'hF7);
    mon_on = 0;
    en = 1'b0;
    ack0 = ack_seen;
    tick();
    check("abort_an", {24'd0, an}, 32'hFF);
    check("abort_cath", {25'd0, cath}, 32'h7F);
    check("abort_frame", {31'd0, frame}, 32'd0);
    repeat (4) tick();
    check("abort_no_ack", ack_seen - ack0, 32'd0);
    sb_q.delete();
    push_frame();
    mon_on = 1;
    en = 1'b1;
    ticks_to_drive("restart_drive", 3);
    check("restart_an", {24'd0, an}, 32'hFE);
    check("restart_cath", {25'd0, cath}, {25'd0, seg_ref(4'h2)});
    frame_step(0); push_frame();
    frame_step(1); push_frame();

    // Reset mid-DRIVE with a load pending.
    tick();
    do_load(32'h33333333);
    tick();
    check("pre_rst_an", {24'd0, an}, 32'hFE);
    mon_on = 0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", {24'd0, an}, 32'hFF);
    check("async_rst_cath", {25'd0, cath}, 32'h7F);
    exp_active = '0; exp_shadow = '0; exp_pending = 0;
    repeat (2) tick();
    sb_q.delete();
    push_frame();
    ack0 = ack_seen;
    rst = 1'b0;
    mon_on = 1;
    ticks_to_drive("post_rst_drive", 4);
    check("post_rst_an", {24'd0, an}, 32'hFE);
    check("post_rst_cath", {25'd0, cath}, 32'b0000001);
    frame_step(0); push_frame();
    frame_step(1);
    check("post_rst_no_ack", ack_seen - ack0, 32'd0);
    mon_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
